// File: rtl/wb_sha_bridge.sv
// Wishbone-classic slave bridging the management bus onto the SHA-256 core register port.
// Decodes a base window, issues a single-cycle core strobe, waits READ_LAT cycles for read data.
module wb_sha_bridge #(
    parameter int          CORE_AW   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] BASE_MASK = 32'hFFFF_FC00,
    parameter int          READ_LAT  = 1,
    parameter bit          ERR_EN    = 1'b1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               wbs_err_o,
    output logic               core_cs,
    output logic               core_we,
    output logic [CORE_AW-1:0] core_address,
    output logic [31:0]        core_write_data,
    input  logic [31:0]        core_read_data
);

    localparam logic [31:0] LOW_MASK = 32'((64'd1 << (CORE_AW + 2)) - 64'd1);
    localparam logic [3:0]  LAT_INIT = (READ_LAT > 0) ? 4'(READ_LAT - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_FAULT
    } state_t;

    state_t             state, state_nxt;
    logic [CORE_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               we_q;
    logic [3:0]         cnt_q;
    logic               abort_q;

    logic req, hit, fault, aborted;
    logic accept, load_cnt, capture;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign hit     = ((wbs_adr_i ^ BASE_ADDR) & BASE_MASK) == 32'd0;
    // Address bits between the word index and the decoded window must be zero.
    assign fault   = !hit || (wbs_sel_i != 4'hF) ||
                     ((wbs_adr_i & ~BASE_MASK & ~LOW_MASK) != 32'd0);
    assign aborted = abort_q | ~wbs_cyc_i;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_cnt  = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept    = !fault;
                    state_nxt = fault ? S_FAULT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_nxt = aborted ? S_IDLE : S_RESP;
                end else if (READ_LAT == 0) begin
                    capture   = 1'b1;
                    state_nxt = aborted ? S_IDLE : S_RESP;
                end else begin
                    load_cnt  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = aborted ? S_IDLE : S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_cs         = 1'b0;
        core_we         = 1'b0;
        core_address    = '0;
        core_write_data = 32'd0;
        wbs_ack_o       = 1'b0;
        wbs_err_o       = 1'b0;
        wbs_dat_o       = 32'd0;
        case (state)
            S_ISSUE: begin
                core_cs         = 1'b1;
                core_we         = we_q;
                core_address    = addr_q;
                core_write_data = wdata_q;
            end
            S_RESP: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = we_q ? 32'd0 : rdata_q;
            end
            S_FAULT: begin
                if (ERR_EN) wbs_err_o = 1'b1;
                else        wbs_ack_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
            abort_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= wbs_adr_i[CORE_AW+1:2];
                wdata_q <= wbs_dat_i;
                we_q    <= wbs_we_i;
            end
            // A dropped cycle is remembered so the core access finishes but never acks.
            if (state == S_IDLE)
                abort_q <= 1'b0;
            else if ((state == S_ISSUE || state == S_WAIT) && !wbs_cyc_i)
                abort_q <= 1'b1;
            if (load_cnt)
                cnt_q <= LAT_INIT;
            else if (state == S_WAIT && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            if (capture)
                rdata_q <= core_read_data;
        end
    end

endmodule

// File: tb/tb_wb_sha_bridge.sv
// Directed bench for wb_sha_bridge: four instances (latency 1/3/2/0, the last with ERR_EN=0)
// share one bus; each scenario checks the instance whose configuration it exercises.
module tb_wb_sha_bridge;

    localparam int I1 = 0;  // READ_LAT=1, ERR_EN=1
    localparam int I3 = 1;  // READ_LAT=3
    localparam int I2 = 2;  // READ_LAT=2
    localparam int I0 = 3;  // READ_LAT=0, ERR_EN=0

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0, dat = 32'd0, crd = 32'd0;

    logic [3:0]  ack, err, cs, cwe;
    logic [31:0] dat_o [4];
    logic [31:0] cwd   [4];
    logic [7:0]  cad   [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_sha_bridge u_l1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_dat_o(dat_o[I1]),
        .wbs_ack_o(ack[I1]), .wbs_err_o(err[I1]), .core_cs(cs[I1]), .core_we(cwe[I1]),
        .core_address(cad[I1]), .core_write_data(cwd[I1]), .core_read_data(crd));

    wb_sha_bridge #(.READ_LAT(3)) u_l3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_dat_o(dat_o[I3]),
        .wbs_ack_o(ack[I3]), .wbs_err_o(err[I3]), .core_cs(cs[I3]), .core_we(cwe[I3]),
        .core_address(cad[I3]), .core_write_data(cwd[I3]), .core_read_data(crd));

    wb_sha_bridge #(.READ_LAT(2)) u_l2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_dat_o(dat_o[I2]),
        .wbs_ack_o(ack[I2]), .wbs_err_o(err[I2]), .core_cs(cs[I2]), .core_we(cwe[I2]),
        .core_address(cad[I2]), .core_write_data(cwd[I2]), .core_read_data(crd));

    wb_sha_bridge #(.READ_LAT(0), .ERR_EN(1'b0)) u_l0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_dat_o(dat_o[I0]),
        .wbs_ack_o(ack[I0]), .wbs_err_o(err[I0]), .core_cs(cs[I0]), .core_we(cwe[I0]),
        .core_address(cad[I0]), .core_write_data(cwd[I0]), .core_read_data(crd));

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat = 32'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        adr = 32'h3000_0010; dat = 32'h5555_AAAA; crd = 32'hFFFF_FFFF;
        tick();
        samp();
        n_tests++; if (ack !== 4'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", ack); end
        n_tests++; if (err !== 4'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0000", err); end
        n_tests++; if (cs  !== 4'b0) begin n_fail++; $display("FAIL rst_cs: got %b want 0000", cs); end
        n_tests++; if (cwe !== 4'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0000", cwe); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (dat_o[i] !== 32'd0) begin n_fail++; $display("FAIL rst_dat[%0d]: got %h want 0", i, dat_o[i]); end
            n_tests++; if (cad[i] !== 8'd0) begin n_fail++; $display("FAIL rst_addr[%0d]: got %h want 0", i, cad[i]); end
            n_tests++; if (cwd[i] !== 32'd0) begin n_fail++; $display("FAIL rst_wdata[%0d]: got %h want 0", i, cwd[i]); end
        end
        do_reset();
    endtask

    task automatic test_write();
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0010; dat = 32'hDEAD_BEEF;
        samp();
        n_tests++; if (cs[I1] !== 1'b0) begin n_fail++; $display("FAIL wr_cs_c0: got %b want 0", cs[I1]); end
        tick();
        // Later bus changes must not leak into the latched request.
        adr = 32'h3000_0044; dat = 32'h1234_5678;
        samp();
        n_tests++; if (cs[I1] !== 1'b1) begin n_fail++; $display("FAIL wr_cs_c1: got %b want 1", cs[I1]); end
        n_tests++; if (cad[I1] !== 8'h04) begin n_fail++; $display("FAIL wr_addr: got %h want 04", cad[I1]); end
        n_tests++; if (cwe[I1] !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", cwe[I1]); end
        n_tests++; if (cwd[I1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeef", cwd[I1]); end
        n_tests++; if (ack[I1] !== 1'b0) begin n_fail++; $display("FAIL wr_ack_c1: got %b want 0", ack[I1]); end
        tick();
        samp();
        n_tests++; if (ack[I1] !== 1'b1) begin n_fail++; $display("FAIL wr_ack_c2: got %b want 1", ack[I1]); end
        n_tests++; if (err[I1] !== 1'b0) begin n_fail++; $display("FAIL wr_err_c2: got %b want 0", err[I1]); end
        n_tests++; if (dat_o[I1] !== 32'd0) begin n_fail++; $display("FAIL wr_dat_c2: got %h want 0", dat_o[I1]); end
        n_tests++; if (cs[I1] !== 1'b0) begin n_fail++; $display("FAIL wr_cs_c2: got %b want 0", cs[I1]); end
        tick();
        cyc = 1'b0; stb = 1'b0;
        samp();
        n_tests++; if (ack[I1] !== 1'b0) begin n_fail++; $display("FAIL wr_ack_c3: got %b want 0", ack[I1]); end
        tick();
    endtask

    task automatic test_read_lat3();
        do_reset();
        crd = 32'd0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0020;
        samp(); tick();
        samp();
        n_tests++; if (cs[I3] !== 1'b1) begin n_fail++; $display("FAIL rd3_cs_c1: got %b want 1", cs[I3]); end
        n_tests++; if (cad[I3] !== 8'h08) begin n_fail++; $display("FAIL rd3_addr: got %h want 08", cad[I3]); end
        n_tests++; if (cwe[I3] !== 1'b0) begin n_fail++; $display("FAIL rd3_we: got %b want 0", cwe[I3]); end
        tick();
        samp();
        n_tests++; if (cs[I3] !== 1'b0) begin n_fail++; $display("FAIL rd3_cs_c2: got %b want 0", cs[I3]); end
        tick();
        tick();
        crd = 32'h6A09_E667;
        samp();
        n_tests++; if (dat_o[I3] !== 32'd0) begin n_fail++; $display("FAIL rd3_dat_c4: got %h want 0", dat_o[I3]); end
        n_tests++; if (ack[I3] !== 1'b0) begin n_fail++; $display("FAIL rd3_ack_c4: got %b want 0", ack[I3]); end
        tick();
        crd = 32'hFFFF_FFFF;
        samp();
        n_tests++; if (ack[I3] !== 1'b1) begin n_fail++; $display("FAIL rd3_ack_c5: got %b want 1", ack[I3]); end
        n_tests++; if (dat_o[I3] !== 32'h6A09_E667) begin n_fail++; $display("FAIL rd3_dat_c5: got %h want 6a09e667", dat_o[I3]); end
        tick();
        cyc = 1'b0; stb = 1'b0;
        samp();
        n_tests++; if (dat_o[I3] !== 32'd0) begin n_fail++; $display("FAIL rd3_dat_c6: got %h want 0", dat_o[I3]); end
        n_tests++; if (ack[I3] !== 1'b0) begin n_fail++; $display("FAIL rd3_ack_c6: got %b want 0", ack[I3]); end
        tick();
    endtask

    task automatic test_read_lat01();
        do_reset();
        crd = 32'd0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0014;
        samp(); tick();
        crd = 32'h3C6E_F372;
        samp();
        n_tests++; if ({cs[I0], cs[I1]} !== 2'b11) begin n_fail++; $display("FAIL rd01_cs: got %b want 11", {cs[I0], cs[I1]}); end
        n_tests++; if (cad[I0] !== 8'h05) begin n_fail++; $display("FAIL rd01_addr: got %h want 05", cad[I0]); end
        tick();
        crd = 32'hA54F_F53A;
        samp();
        n_tests++; if (ack[I0] !== 1'b1) begin n_fail++; $display("FAIL rd0_ack: got %b want 1", ack[I0]); end
        n_tests++; if (dat_o[I0] !== 32'h3C6E_F372) begin n_fail++; $display("FAIL rd0_dat: got %h want 3c6ef372", dat_o[I0]); end
        n_tests++; if (ack[I1] !== 1'b0) begin n_fail++; $display("FAIL rd1_ack_early: got %b want 0", ack[I1]); end
        tick();
        crd = 32'd0; cyc = 1'b0; stb = 1'b0;
        samp();
        n_tests++; if (ack[I1] !== 1'b1) begin n_fail++; $display("FAIL rd1_ack: got %b want 1", ack[I1]); end
        n_tests++; if (dat_o[I1] !== 32'hA54F_F53A) begin n_fail++; $display("FAIL rd1_dat: got %h want a54ff53a", dat_o[I1]); end
        tick();
    endtask

    task automatic test_fault();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            crd = 32'hFFFF_FFFF;
            cyc = 1'b1; stb = 1'b1; sel = (v == 0) ? 4'hF : 4'h3; we = (v == 1);
            adr = (v == 0) ? 32'h3000_0400 : 32'h3000_0010; dat = 32'h0BAD_F00D;
            samp();
            n_tests++; if (cs !== 4'b0) begin n_fail++; $display("FAIL flt%0d_cs_c0: got %b want 0000", v, cs); end
            tick();
            samp();
            n_tests++; if (err[I1] !== 1'b1) begin n_fail++; $display("FAIL flt%0d_err: got %b want 1", v, err[I1]); end
            n_tests++; if (ack[I1] !== 1'b0) begin n_fail++; $display("FAIL flt%0d_ack_en: got %b want 0", v, ack[I1]); end
            n_tests++; if (ack[I0] !== 1'b1) begin n_fail++; $display("FAIL flt%0d_ack_dis: got %b want 1", v, ack[I0]); end
            n_tests++; if (err[I0] !== 1'b0) begin n_fail++; $display("FAIL flt%0d_err_dis: got %b want 0", v, err[I0]); end
            n_tests++; if (dat_o[I0] !== 32'd0) begin n_fail++; $display("FAIL flt%0d_dat: got %h want 0", v, dat_o[I0]); end
            n_tests++; if (cs !== 4'b0) begin n_fail++; $display("FAIL flt%0d_cs_c1: got %b want 0000", v, cs); end
            tick();
            cyc = 1'b0; stb = 1'b0;
            samp();
            n_tests++; if ({err[I1], ack[I0]} !== 2'b00) begin n_fail++; $display("FAIL flt%0d_c2: got %b want 00", v, {err[I1], ack[I0]}); end
            n_tests++; if (cs !== 4'b0) begin n_fail++; $display("FAIL flt%0d_cs_c2: got %b want 0000", v, cs); end
            tick();
        end
    endtask

    task automatic test_abort();
        int   ncs;
        logic rsp;
        ncs = 0; rsp = 1'b0;
        do_reset();
        crd = 32'h1111_1111;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0008;
        samp(); tick();
        samp(); ncs += int'(cs[I2]); tick();
        cyc = 1'b0; stb = 1'b0;
        samp(); ncs += int'(cs[I2]); rsp |= ack[I2] | err[I2]; tick();
        samp(); ncs += int'(cs[I2]); rsp |= ack[I2] | err[I2]; tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0004; dat = 32'hCAFE_F00D;
        samp(); ncs += int'(cs[I2]); rsp |= ack[I2] | err[I2];
        n_tests++; if (ncs != 1) begin n_fail++; $display("FAIL abort_cs_pulses: got %0d want 1", ncs); end
        n_tests++; if (rsp !== 1'b0) begin n_fail++; $display("FAIL abort_resp: got %b want 0", rsp); end
        tick();
        samp();
        n_tests++; if (cs[I2] !== 1'b1) begin n_fail++; $display("FAIL abort_next_cs: got %b want 1", cs[I2]); end
        n_tests++; if (cad[I2] !== 8'h01) begin n_fail++; $display("FAIL abort_next_addr: got %h want 01", cad[I2]); end
        n_tests++; if (cwe[I2] !== 1'b1) begin n_fail++; $display("FAIL abort_next_we: got %b want 1", cwe[I2]); end
        tick();
        samp();
        n_tests++; if (ack[I2] !== 1'b1) begin n_fail++; $display("FAIL abort_next_ack: got %b want 1", ack[I2]); end
        tick();
        cyc = 1'b0; stb = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic stray;
        stray = 1'b0;
        do_reset();
        crd = 32'h2222_2222;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0020;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        samp();
        n_tests++; if ({ack, err, cs, cwe} !== 16'd0) begin n_fail++; $display("FAIL rstmid_ctl: got %h want 0", {ack, err, cs, cwe}); end
        n_tests++; if ({dat_o[I3], cwd[I3], cad[I3]} !== 72'd0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", {dat_o[I3], cwd[I3], cad[I3]}); end
        tick();
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0030; crd = 32'hBB67_AE85;
        samp(); stray |= ack[I3] | err[I3]; tick();
        samp();
        n_tests++; if (cs[I3] !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs: got %b want 1", cs[I3]); end
        n_tests++; if (cad[I3] !== 8'h0C) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0c", cad[I3]); end
        tick();
        for (int c = 6; c < 9; c++) begin
            samp(); stray |= ack[I3] | err[I3]; tick();
        end
        samp();
        n_tests++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_resp: got %b want 0", stray); end
        n_tests++; if (ack[I3] !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got %b want 1", ack[I3]); end
        n_tests++; if (dat_o[I3] !== 32'hBB67_AE85) begin n_fail++; $display("FAIL rstmid_dat: got %h want bb67ae85", dat_o[I3]); end
        tick();
        cyc = 1'b0; stb = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int   ncs, nack;
        logic exp_cs, exp_ack;
        ncs = 0; nack = 0;
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        for (int c = 0; c <= 12; c++) begin
            if (c % 3 == 0 && c < 12) begin
                adr = 32'h3000_0000 + 32'(4 * (c / 3));
                dat = 32'hA000_0000 + 32'(c / 3);
            end
            if (c == 12) begin cyc = 1'b0; stb = 1'b0; end
            samp();
            exp_cs  = (c % 3 == 1);
            exp_ack = (c % 3 == 2);
            ncs  += int'(cs[I0]);
            nack += int'(ack[I0]);
            n_tests++; if (cs[I0] !== exp_cs) begin n_fail++; $display("FAIL b2b_cs_c%0d: got %b want %b", c, cs[I0], exp_cs); end
            n_tests++; if (ack[I0] !== exp_ack) begin n_fail++; $display("FAIL b2b_ack_c%0d: got %b want %b", c, ack[I0], exp_ack); end
            if (exp_cs) begin
                n_tests++; if (cad[I0] !== 8'(c / 3)) begin n_fail++; $display("FAIL b2b_addr_c%0d: got %h want %h", c, cad[I0], 8'(c / 3)); end
                n_tests++; if (cwd[I0] !== 32'hA000_0000 + 32'(c / 3)) begin n_fail++; $display("FAIL b2b_wdata_c%0d: got %h want %h", c, cwd[I0], 32'hA000_0000 + 32'(c / 3)); end
            end
            tick();
        end
        n_tests++; if (ncs != 4) begin n_fail++; $display("FAIL b2b_cs_count: got %0d want 4", ncs); end
        n_tests++; if (nack != 4) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 4", nack); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_lat3();
        test_read_lat01();
        test_fault();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
